// File: rtl/x68_sd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : x68_sd_pkg
//  Purpose  : Shared types and constants for the X68 virtual-disk arbiter.
//             Holds the arbiter state and operation encodings, the sector
//             size, the fixed client slot numbers and a round-robin helper.
//  Revision : 1.0  initial release
// ============================================================================
package x68_sd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        FIN   = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int SECT_BYTES = 512;
    localparam int BUF_AW     = $clog2(SECT_BYTES);

    // Fixed client slots on the request vectors
    localparam int CL_FDD0 = 0;
    localparam int CL_FDD1 = 1;
    localparam int CL_SASI = 2;
    localparam int CL_SRAM = 3;

    // Single-step modular wrap: valid for a < 2*n, which covers both the
    // search offset (ptr + i) and the pointer advance (grant + 1).
    function automatic int unsigned rr_wrap(input int unsigned a, input int unsigned n);
        return (a >= n) ? (a - n) : a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/x68_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : x68_rr_pick
//  Purpose  : Combinational round-robin first-set finder. Searches the
//             pending vector upward from ptr with wrap-around and reports
//             the first set position.
//  Ports    : pending [NREQ]  request vector
//             ptr     [PTR_W] search start position
//             hit             any request found
//             idx     [PTR_W] position of the first request in search order
//  Revision : 1.0  initial release
// ============================================================================
module x68_rr_pick
    import x68_sd_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  pending,
    input  logic [PTR_W-1:0] ptr,
    output logic             hit,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] w_pos;

    // Walk the search order backwards so the last assignment made is the
    // earliest position in search order; avoids a priority chain flag.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        w_pos = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_pos = PTR_W'(rr_wrap(32'(ptr) + 32'(i), NREQ));
            if (pending[w_pos]) begin
                hit = 1'b1;
                idx = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/x68_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : x68_sd_arbiter
//  Purpose  : Shares the single hps_io virtual-disk channel among NREQ image
//             clients (FDD0, FDD1, SASI, SRAM) with one outstanding command,
//             round-robin fairness and per-client done / timeout pulses.
//  Ports    : sysclk, rstn             clock, synchronous active-low reset
//             cl_rd/cl_wr/cl_lba       per-client request levels and LBAs
//             cl_buff_din              per-client sector data for writes
//             cl_done/cl_err           per-client completion / timeout pulse
//             cl_buff_wr               buffer strobe to the granted client
//             cl_buff_addr/cl_buff_dout broadcast buffer address / data
//             busy                     arbiter not idle
//             sd_*                     hps_io virtual-disk interface
//  Revision : 1.0  initial release
// ============================================================================
module x68_sd_arbiter
    import x68_sd_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TMO_W = 24
) (
    input  logic                  sysclk,
    input  logic                  rstn,
    input  logic [NREQ-1:0]       cl_rd,
    input  logic [NREQ-1:0]       cl_wr,
    input  logic [32*NREQ-1:0]    cl_lba,
    input  logic [8*NREQ-1:0]     cl_buff_din,
    output logic [NREQ-1:0]       cl_done,
    output logic [NREQ-1:0]       cl_err,
    output logic [NREQ-1:0]       cl_buff_wr,
    output logic [BUF_AW-1:0]     cl_buff_addr,
    output logic [7:0]            cl_buff_dout,
    output logic                  busy,
    output logic [31:0]           sd_lba,
    output logic [NREQ-1:0]       sd_rd,
    output logic [NREQ-1:0]       sd_wr,
    input  logic                  sd_ack,
    input  logic [BUF_AW-1:0]     sd_buff_addr,
    input  logic [7:0]            sd_buff_dout,
    input  logic                  sd_buff_wr,
    output logic [7:0]            sd_buff_din
);

    localparam int               PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    // Last counter value at which a missing ack is still tolerated; the
    // command is abandoned on the edge that would reach all-ones.
    localparam logic [TMO_W-1:0] TMO_LAST = ~TMO_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    op_t              r_op;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_grant;
    logic [PTR_W-1:0] w_pick_idx;
    logic [PTR_W-1:0] w_ptr_next;
    logic             w_pick_hit;
    logic [31:0]      r_lba;
    logic [TMO_W-1:0] r_tmo;
    logic [NREQ-1:0]  r_err;
    logic [NREQ-1:0]  w_grant_oh;
    logic             w_take;
    logic             w_tmo_fire;
    logic [31:0]      w_lba_arr [NREQ];
    logic [7:0]       w_din_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_lba_arr[gi] = cl_lba[32*gi +: 32];
        assign w_din_arr[gi] = cl_buff_din[8*gi +: 8];
    end

    x68_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .pending (cl_rd | cl_wr),
        .ptr     (r_rr_ptr),
        .hit     (w_pick_hit),
        .idx     (w_pick_idx)
    );

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge sysclk) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_tmo_fire  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_hit) begin
                    w_take      = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // An ack already high on entry is accepted on the first edge.
                if (sd_ack) begin
                    w_state_nxt = XFER;
                end else if (r_tmo == TMO_LAST) begin
                    w_tmo_fire  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command latch, timeout counter, fairness pointer
    // ------------------------------------------------------------------
    assign w_ptr_next = PTR_W'(rr_wrap(32'(r_grant) + 32'd1, NREQ));

    always_ff @(posedge sysclk) begin
        if (!rstn) begin
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_op     <= OP_RD;
            r_lba    <= '0;
            r_tmo    <= '0;
            r_err    <= '0;
        end else begin
            r_err <= '0;
            // The command is captured once; later changes to the client's
            // request levels or LBA do not affect it.
            if (w_take) begin
                r_grant <= w_pick_idx;
                r_lba   <= w_lba_arr[w_pick_idx];
                r_op    <= cl_wr[w_pick_idx] ? OP_WR : OP_RD;
            end
            if (r_state == ISSUE && !sd_ack && !w_tmo_fire) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
            if (w_tmo_fire) begin
                r_err <= w_grant_oh;
            end
            if (w_tmo_fire || r_state == FIN) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_grant_oh   = NREQ'(1) << r_grant;

    // ISSUE is entered on the edge that samples the request, so these
    // strobes appear one cycle after the request and never overlap.
    assign sd_rd        = (r_state == ISSUE && r_op == OP_RD) ? w_grant_oh : '0;
    assign sd_wr        = (r_state == ISSUE && r_op == OP_WR) ? w_grant_oh : '0;
    assign sd_lba       = r_lba;

    assign cl_done      = (r_state == FIN) ? w_grant_oh : '0;
    assign cl_err       = r_err;
    assign cl_buff_wr   = (r_state == XFER && sd_buff_wr) ? w_grant_oh : '0;
    assign cl_buff_addr = sd_buff_addr;
    assign cl_buff_dout = sd_buff_dout;
    assign sd_buff_din  = w_din_arr[r_grant];
    assign busy         = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_x68_sd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_x68_sd_arbiter
//  Purpose  : Self-checking bench for x68_sd_arbiter. A small host model
//             answers commands; a reference model of round-robin selection
//             predicts grant, operation and LBA for directed and random
//             request patterns.
//  Revision : 1.0  initial release
// ============================================================================
module tb_x68_sd_arbiter;
    import x68_sd_pkg::*;

    localparam int NREQ  = 4;
    localparam int TMO_W = 4;

    logic                  sysclk = 1'b0;
    logic                  rstn;
    logic [NREQ-1:0]       cl_rd, cl_wr, cl_done, cl_err, cl_buff_wr, sd_rd, sd_wr;
    logic [32*NREQ-1:0]    cl_lba;
    logic [8*NREQ-1:0]     cl_buff_din;
    logic [BUF_AW-1:0]     cl_buff_addr, sd_buff_addr;
    logic [7:0]            cl_buff_dout, sd_buff_dout, sd_buff_din;
    logic                  busy, sd_ack, sd_buff_wr;
    logic [31:0]           sd_lba;

    int n_checks  = 0;
    int n_pass    = 0;
    int model_ptr = 0;

    int mon_bwr  [NREQ];
    int mon_done [NREQ];
    int mon_err  [NREQ];
    int mon_multi = 0;

    x68_sd_arbiter #(
        .NREQ  (NREQ),
        .TMO_W (TMO_W)
    ) dut (
        .sysclk       (sysclk),
        .rstn         (rstn),
        .cl_rd        (cl_rd),
        .cl_wr        (cl_wr),
        .cl_lba       (cl_lba),
        .cl_buff_din  (cl_buff_din),
        .cl_done      (cl_done),
        .cl_err       (cl_err),
        .cl_buff_wr   (cl_buff_wr),
        .cl_buff_addr (cl_buff_addr),
        .cl_buff_dout (cl_buff_dout),
        .busy         (busy),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din)
    );

    always #5 sysclk = ~sysclk;

    // Event counters sampled on the falling edge
    always @(negedge sysclk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (cl_buff_wr[i] === 1'b1) mon_bwr[i]++;
            if (cl_done[i] === 1'b1)    mon_done[i]++;
            if (cl_err[i] === 1'b1)     mon_err[i]++;
        end
        if ($countones(sd_rd) + $countones(sd_wr) > 1) mon_multi++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference: first pending client at or after ptr, modulo NREQ
    function automatic int model_pick(input logic [NREQ-1:0] pend, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [NREQ-1:0] oh(input int i);
        return NREQ'(1) << i;
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        model_ptr = 0;
    endtask

    // Host side: wait for a command strobe, bounded
    task automatic wait_issue(output int lat);
        lat = 0;
        while (sd_rd == '0 && sd_wr == '0 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic ack_xfer(input int ack_dly, input int nbytes);
        repeat (ack_dly) tick();
        sd_ack = 1'b1;
        tick();
        for (int b = 0; b < nbytes; b++) begin
            sd_buff_addr = BUF_AW'(b);
            sd_buff_dout = 8'($urandom);
            sd_buff_wr   = 1'b1;
            tick();
            sd_buff_wr   = 1'b0;
            tick();
        end
    endtask

    // Drops ack; returns cl_done in the cycle after ack falls and the next one
    task automatic finish_cmd(output logic [NREQ-1:0] d_fin, output logic [NREQ-1:0] d_after);
        sd_ack = 1'b0;
        tick();
        d_fin = cl_done;
        tick();
        d_after = cl_done;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        cl_rd = '0; cl_wr = '0; sd_ack = 1'b0; sd_buff_wr = 1'b0;
        sd_buff_addr = 9'h1a5; sd_buff_dout = 8'h3c;
        cl_lba = {$urandom, $urandom, $urandom, $urandom};
        cl_buff_din = $urandom;
        tick(); tick();
        n_checks++; if (sd_rd !== '0) $display("FAIL reset_sd_rd got %b want 0", sd_rd); else n_pass++;
        n_checks++; if (sd_wr !== '0) $display("FAIL reset_sd_wr got %b want 0", sd_wr); else n_pass++;
        n_checks++; if (sd_lba !== 32'h0) $display("FAIL reset_sd_lba got %h want 0", sd_lba); else n_pass++;
        n_checks++; if (cl_done !== '0) $display("FAIL reset_done got %b want 0", cl_done); else n_pass++;
        n_checks++; if (cl_err !== '0) $display("FAIL reset_err got %b want 0", cl_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (cl_buff_wr !== '0) $display("FAIL reset_buff_wr got %b want 0", cl_buff_wr); else n_pass++;
        n_checks++; if (cl_buff_addr !== 9'h1a5) $display("FAIL addr_pass got %h want 1a5", cl_buff_addr); else n_pass++;
        n_checks++; if (cl_buff_dout !== 8'h3c) $display("FAIL dout_pass got %h want 3c", cl_buff_dout); else n_pass++;
        n_checks++; if (sd_buff_din !== cl_buff_din[7:0]) $display("FAIL reset_din got %h want %h", sd_buff_din, cl_buff_din[7:0]); else n_pass++;
        rstn = 1'b1;
        model_ptr = 0;
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_single_read();
        int lat;
        int b0 [NREQ];
        int others;
        logic [NREQ-1:0] df, da;
        b0 = mon_bwr;
        cl_lba[31:0] = 32'h0000_0123;
        cl_rd = 4'b0001;
        wait_issue(lat);
        n_checks++; if (lat !== 1) $display("FAIL single_latency got %0d want 1", lat); else n_pass++;
        n_checks++; if (sd_rd !== 4'b0001) $display("FAIL single_sd_rd got %b want 0001", sd_rd); else n_pass++;
        n_checks++; if (sd_wr !== 4'b0000) $display("FAIL single_sd_wr got %b want 0000", sd_wr); else n_pass++;
        n_checks++; if (sd_lba !== 32'h123) $display("FAIL single_lba got %h want 123", sd_lba); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy got %b want 1", busy); else n_pass++;
        ack_xfer(3, SECT_BYTES);
        finish_cmd(df, da);
        cl_rd = '0;
        others = 0;
        for (int i = 1; i < NREQ; i++) others += mon_bwr[i] - b0[i];
        n_checks++; if (mon_bwr[0] - b0[0] !== SECT_BYTES) $display("FAIL single_bwr0 got %0d want %0d", mon_bwr[0] - b0[0], SECT_BYTES); else n_pass++;
        n_checks++; if (others !== 0) $display("FAIL single_bwr_other got %0d want 0", others); else n_pass++;
        n_checks++; if (df !== 4'b0001) $display("FAIL single_done got %b want 0001", df); else n_pass++;
        n_checks++; if (da !== 4'b0000) $display("FAIL single_done_len got %b want 0000", da); else n_pass++;
        model_ptr = (0 + 1) % NREQ;
    endtask

    task automatic test_round_robin();
        int lat, exp;
        int m0;
        logic [NREQ-1:0] df, da;
        do_reset();
        m0 = mon_multi;
        cl_rd = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp = model_pick(cl_rd | cl_wr, model_ptr);
            wait_issue(lat);
            n_checks++; if (sd_rd !== oh(exp)) $display("FAIL rr_grant_%0d got %b want %b", k, sd_rd, oh(exp)); else n_pass++;
            ack_xfer($urandom_range(0, 4), 2);
            finish_cmd(df, da);
            n_checks++; if (df !== oh(exp)) $display("FAIL rr_done_%0d got %b want %b", k, df, oh(exp)); else n_pass++;
            model_ptr = (exp + 1) % NREQ;
        end
        cl_rd = '0;
        n_checks++; if (mon_multi - m0 !== 0) $display("FAIL rr_multihot got %0d want 0", mon_multi - m0); else n_pass++;
    endtask

    task automatic test_write_priority();
        int lat;
        logic [7:0] v;
        logic [NREQ-1:0] df, da;
        cl_rd = 4'b0100;
        cl_wr = 4'b0100;
        wait_issue(lat);
        n_checks++; if (sd_wr !== 4'b0100) $display("FAIL wr_sd_wr got %b want 0100", sd_wr); else n_pass++;
        n_checks++; if (sd_rd !== 4'b0000) $display("FAIL wr_sd_rd got %b want 0000", sd_rd); else n_pass++;
        sd_ack = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            v = 8'($urandom);
            cl_buff_din[23:16] = v;
            cl_buff_din[7:0]   = ~v;
            #1;
            n_checks++; if (sd_buff_din !== v) $display("FAIL wr_din_%0d got %h want %h", k, sd_buff_din, v); else n_pass++;
            tick();
        end
        finish_cmd(df, da);
        cl_rd = '0;
        cl_wr = '0;
        n_checks++; if (df !== 4'b0100) $display("FAIL wr_done got %b want 0100", df); else n_pass++;
        model_ptr = (2 + 1) % NREQ;
    endtask

    task automatic test_timeout();
        int lat, cnt, exp;
        logic [NREQ-1:0] df, da;
        // Move the fairness pointer away from 0 first
        cl_rd = 4'b0010;
        wait_issue(lat);
        ack_xfer(0, 1);
        finish_cmd(df, da);
        cl_rd = '0;
        model_ptr = (1 + 1) % NREQ;
        cl_wr = 4'b1000;
        wait_issue(lat);
        n_checks++; if (sd_wr !== 4'b1000) $display("FAIL tmo_sd_wr got %b want 1000", sd_wr); else n_pass++;
        cnt = 1;
        while (cnt < 40) begin
            tick();
            if (sd_wr == '0) break;
            cnt++;
        end
        n_checks++; if (cnt !== 15) $display("FAIL tmo_cycles got %0d want 15", cnt); else n_pass++;
        n_checks++; if (cl_err !== 4'b1000) $display("FAIL tmo_err got %b want 1000", cl_err); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL tmo_busy got %b want 0", busy); else n_pass++;
        cl_wr = '0;
        model_ptr = (3 + 1) % NREQ;
        tick();
        n_checks++; if (cl_err !== '0) $display("FAIL tmo_err_len got %b want 0", cl_err); else n_pass++;
        cl_rd = 4'b0101;
        exp = model_pick(cl_rd | cl_wr, model_ptr);
        wait_issue(lat);
        n_checks++; if (sd_rd !== oh(exp)) $display("FAIL tmo_next_grant got %b want %b", sd_rd, oh(exp)); else n_pass++;
        ack_xfer(0, 1);
        finish_cmd(df, da);
        cl_rd = '0;
        model_ptr = (exp + 1) % NREQ;
    endtask

    task automatic test_reset_mid_xfer();
        int lat, d0, e0, d1, e1;
        cl_rd = 4'b0010;
        wait_issue(lat);
        sd_ack = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_xfer_busy got %b want 1", busy); else n_pass++;
        d0 = 0; e0 = 0;
        for (int i = 0; i < NREQ; i++) begin d0 += mon_done[i]; e0 += mon_err[i]; end
        rstn  = 1'b0;
        cl_rd = '0;
        tick();
        rstn   = 1'b1;
        sd_ack = 1'b0;
        model_ptr = 0;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else n_pass++;
        n_checks++; if ((sd_rd | sd_wr) !== '0) $display("FAIL rst_mid_cmd got %b want 0", sd_rd | sd_wr); else n_pass++;
        repeat (4) tick();
        d1 = 0; e1 = 0;
        for (int i = 0; i < NREQ; i++) begin d1 += mon_done[i]; e1 += mon_err[i]; end
        n_checks++; if (d1 - d0 !== 0) $display("FAIL rst_mid_done got %0d want 0", d1 - d0); else n_pass++;
        n_checks++; if (e1 - e0 !== 0) $display("FAIL rst_mid_err got %0d want 0", e1 - e0); else n_pass++;
    endtask

    task automatic test_request_drop();
        int lat;
        logic [NREQ-1:0] df, da;
        cl_rd = 4'b0010;
        wait_issue(lat);
        cl_rd = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (sd_rd !== 4'b0010) $display("FAIL drop_hold_%0d got %b want 0010", k, sd_rd); else n_pass++;
        end
        ack_xfer(0, 2);
        finish_cmd(df, da);
        n_checks++; if (df !== 4'b0010) $display("FAIL drop_done got %b want 0010", df); else n_pass++;
        model_ptr = (1 + 1) % NREQ;
    endtask

    task automatic test_random();
        int lat, exp, nb, others, m0;
        logic exp_wr;
        logic [31:0] exp_lba;
        int b0 [NREQ];
        logic [NREQ-1:0] df, da;
        m0 = mon_multi;
        for (int it = 0; it < 20; it++) begin
            cl_rd = cl_rd | NREQ'($urandom);
            cl_wr = cl_wr | (NREQ'($urandom) & NREQ'($urandom));
            if ((cl_rd | cl_wr) == '0) cl_rd[$urandom_range(0, NREQ - 1)] = 1'b1;
            cl_lba      = {$urandom, $urandom, $urandom, $urandom};
            cl_buff_din = $urandom;
            exp     = model_pick(cl_rd | cl_wr, model_ptr);
            exp_wr  = cl_wr[exp];
            exp_lba = cl_lba[32*exp +: 32];
            b0 = mon_bwr;
            wait_issue(lat);
            n_checks++; if (lat !== 1) $display("FAIL rnd_lat_%0d got %0d want 1", it, lat); else n_pass++;
            n_checks++; if ({sd_wr, sd_rd} !== (exp_wr ? {oh(exp), 4'b0} : {4'b0, oh(exp)}))
                $display("FAIL rnd_cmd_%0d got wr=%b rd=%b want client %0d wr=%b", it, sd_wr, sd_rd, exp, exp_wr); else n_pass++;
            n_checks++; if (sd_lba !== exp_lba) $display("FAIL rnd_lba_%0d got %h want %h", it, sd_lba, exp_lba); else n_pass++;
            nb = $urandom_range(1, 6);
            ack_xfer($urandom_range(0, 5), nb);
            finish_cmd(df, da);
            others = 0;
            for (int i = 0; i < NREQ; i++) if (i != exp) others += mon_bwr[i] - b0[i];
            n_checks++; if (mon_bwr[exp] - b0[exp] !== nb) $display("FAIL rnd_bwr_%0d got %0d want %0d", it, mon_bwr[exp] - b0[exp], nb); else n_pass++;
            n_checks++; if (others !== 0) $display("FAIL rnd_bwr_other_%0d got %0d want 0", it, others); else n_pass++;
            n_checks++; if (df !== oh(exp)) $display("FAIL rnd_done_%0d got %b want %b", it, df, oh(exp)); else n_pass++;
            n_checks++; if (sd_buff_din !== cl_buff_din[8*exp +: 8]) $display("FAIL rnd_din_%0d got %h want %h", it, sd_buff_din, cl_buff_din[8*exp +: 8]); else n_pass++;
            cl_rd[exp] = 1'b0;
            cl_wr[exp] = 1'b0;
            model_ptr = (exp + 1) % NREQ;
        end
        cl_rd = '0;
        cl_wr = '0;
        n_checks++; if (mon_multi - m0 !== 0) $display("FAIL rnd_multihot got %0d want 0", mon_multi - m0); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_priority();
        test_timeout();
        test_reset_mid_xfer();
        test_request_drop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
